// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared FSM encoding and address-alignment helpers
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int byte_offset(input int data_bw);
        return clogb2(data_bw / 8);
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command, BRAM read port and output stream of the reader
interface bram_stream_reader_if #(
    parameter int ADDR_BW = 10,
    parameter int DATA_BW = 32,
    parameter int LEN_BW  = 11
);
    logic               i_start;
    logic [ADDR_BW-1:0] i_base_addr;
    logic [LEN_BW-1:0]  i_len;
    logic               o_busy;
    logic               o_done;
    logic               o_r_en;
    logic [ADDR_BW-1:0] o_r_addr;
    logic [DATA_BW-1:0] i_r_data;
    logic               o_m_valid;
    logic [DATA_BW-1:0] o_m_data;
    logic               o_m_last;
    logic               i_m_ready;

    modport master (
        input  i_start, i_base_addr, i_len, i_r_data, i_m_ready,
        output o_busy, o_done, o_r_en, o_r_addr, o_m_valid, o_m_data, o_m_last
    );

    modport slave (
        output i_start, i_base_addr, i_len, i_r_data, i_m_ready,
        input  o_busy, o_done, o_r_en, o_r_addr, o_m_valid, o_m_data, o_m_last
    );
endinterface

// File: rtl/bram_stream_reader_skid_fifo2.sv
// skid_fifo2: 2-entry synchronous FIFO holding BRAM words tagged with a last flag
module skid_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   count_q;

    assign dout_o  = mem_q[rd_q];
    assign count_o = count_q;

    // storage and pointers; the producer's credit rule keeps pushes off a full buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) mem_q[wr_q] <= din_i;
            wr_q    <= wr_q ^ push_i;
            rd_q    <= rd_q ^ pop_i;
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a word region of a BRAM read port and streams it out with last
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_BW = 10,
    parameter int DATA_BW = 32,
    parameter int LEN_BW  = 11
) (
    input logic               clk,
    input logic               rst,
    bram_stream_reader_if.master bus
);
    localparam int BYTE_OFFSET = byte_offset(DATA_BW);
    localparam logic [ADDR_BW-1:0] ALIGN_MASK = ~ADDR_BW'((1 << BYTE_OFFSET) - 1);

    state_t             state_q, state_d;
    logic [ADDR_BW-1:0] base_q, base_d;
    logic [LEN_BW-1:0]  len_q, len_d;
    logic [LEN_BW-1:0]  issued_q, issued_d;
    logic [LEN_BW-1:0]  beat_q, beat_d;
    logic               inflight_q;
    logic               done_q, done_d;
    logic [1:0]         count;
    logic [DATA_BW:0]   head;
    logic               valid;
    logic               pop;
    logic               r_en;
    logic               last_issue;
    logic               push_last;

    assign valid      = count != 2'd0;
    assign pop        = valid & bus.i_m_ready;
    assign r_en       = (state_q == RUN) && ((3'(count) + 3'(inflight_q) - 3'(pop)) < 3'd2);
    assign last_issue = issued_q == len_q - LEN_BW'(1);
    assign push_last  = beat_q == len_q - LEN_BW'(1);

    skid_fifo2 #(.W(DATA_BW + 1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({push_last, bus.i_r_data}),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count)
    );

    assign bus.o_busy    = state_q != IDLE;
    assign bus.o_done    = done_q;
    assign bus.o_r_en    = r_en;
    assign bus.o_r_addr  = base_q + (ADDR_BW'(issued_q) << BYTE_OFFSET);
    assign bus.o_m_valid = valid;
    assign bus.o_m_data  = valid ? head[DATA_BW-1:0] : '0;
    assign bus.o_m_last  = valid & head[DATA_BW];

    // next state: start latching, last-issue hand-off to DRAIN, completion on the last beat
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q + LEN_BW'(r_en);
        beat_d   = beat_q + LEN_BW'(inflight_q);
        done_d   = 1'b0;
        if (state_q == IDLE && bus.i_start) begin
            if (bus.i_len != '0) begin
                state_d  = RUN;
                base_d   = bus.i_base_addr & ALIGN_MASK;
                len_d    = bus.i_len;
                issued_d = '0;
                beat_d   = '0;
            end else begin
                done_d = 1'b1;
            end
        end
        if (state_q == RUN && r_en && last_issue) state_d = DRAIN;
        if (state_q == DRAIN && pop && bus.o_m_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // state registers; clearing inflight on reset drops any word still returning from the BRAM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= r_en;
            done_q     <= done_d;
        end
    end
endmodule
